// File: rtl/ecc_scrub_ctrl.sv
// Arbitrates an ECC word array between one client port and a periodic scrubber; read rsp 1 cycle after accept.
// Backpressure: req_ready drops on the scrub start cycle and while the scrubber owns the array (1-2 cycles).
module ecc_scrub_ctrl #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int SCRUB_INTERVAL = 64,
  parameter int MAX_DEFER      = 8,
  parameter int ERRCNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err,
  output logic                scrub_busy,
  output logic                scrub_done,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(SCRUB_INTERVAL);
  localparam int DEF_W = $clog2(MAX_DEFER + 1);

  typedef enum logic [1:0] {IDLE, SCRUB_RD, SCRUB_WR} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    ivl_cnt;
  logic                scrub_pend;
  logic [DEF_W-1:0]    defer_cnt;
  logic [ADDR_W-1:0]   scrub_ptr;
  logic [DATA_W-1:0]   scrub_data;

  logic tick;
  logic scrub_start;
  logic scrub_fin;
  logic accept;

  assign tick        = (ivl_cnt == CNT_W'(SCRUB_INTERVAL - 1));
  assign scrub_start = (state == IDLE) && scrub_pend &&
                       (!req_valid || (defer_cnt == DEF_W'(MAX_DEFER)));
  assign scrub_fin   = ((state == SCRUB_RD) && !mem_err) || (state == SCRUB_WR);
  assign accept      = req_valid && req_ready;

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_addr   = scrub_ptr;
    mem_we     = 1'b0;
    mem_wdata  = scrub_data;
    scrub_busy = 1'b0;
    case (state)
      IDLE: begin
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        if (scrub_start) begin
          state_nxt = SCRUB_RD;
        end else begin
          req_ready = 1'b1;
          mem_we    = req_valid && req_we;
        end
      end
      SCRUB_RD: begin
        scrub_busy = 1'b1;
        state_nxt  = mem_err ? SCRUB_WR : IDLE;
      end
      SCRUB_WR: begin
        scrub_busy = 1'b1;
        mem_we     = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A reset landing mid-scrub must not let the pending write-back reach the array.
    if (rst) begin
      req_ready  = 1'b0;
      mem_we     = 1'b0;
      scrub_busy = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ivl_cnt    <= '0;
      scrub_pend <= 1'b0;
      defer_cnt  <= '0;
      scrub_ptr  <= '0;
      scrub_data <= '0;
      scrub_done <= 1'b0;
      err_count  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ivl_cnt <= tick ? '0 : ivl_cnt + 1'b1;

      // A tick coinciding with scrub completion keeps the request pending.
      if (tick)
        scrub_pend <= 1'b1;
      else if (scrub_fin)
        scrub_pend <= 1'b0;

      if (scrub_start)
        defer_cnt <= '0;
      else if (scrub_pend && accept && (defer_cnt != DEF_W'(MAX_DEFER)))
        defer_cnt <= defer_cnt + 1'b1;

      if (state == SCRUB_RD)
        scrub_data <= mem_rdata;

      if (scrub_fin)
        scrub_ptr <= scrub_ptr + 1'b1;
      scrub_done <= scrub_fin && (scrub_ptr == '1);

      if ((state == SCRUB_WR) && (err_count != '1))
        err_count <= err_count + 1'b1;

      rsp_valid <= accept && !req_we;
      if (accept && !req_we) begin
        rsp_rdata <= mem_rdata;
        rsp_err   <= mem_err;
      end
    end
  end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a behavioural ECC array and a read-response scoreboard.
module tb_ecc_scrub_ctrl;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_err;
  logic       scrub_busy;
  logic       scrub_done;
  logic [7:0] err_count;

  // Array model: one optional injected error word overrides the stored contents.
  logic [7:0] tbmem [16] = '{default: 8'h00};
  logic       inj_en = 1'b0;
  logic [3:0] inj_addr = '0;
  logic [7:0] inj_data = '0;

  assign mem_err   = inj_en && (mem_addr == inj_addr);
  assign mem_rdata = mem_err ? inj_data : tbmem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) tbmem[mem_addr] <= mem_wdata;
  end

  always #5 clk = ~clk;

  ecc_scrub_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .scrub_busy (scrub_busy),
    .scrub_done (scrub_done),
    .err_count  (err_count)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   deferred = 0;
  int   tick_at = 0;
  logic [3:0] last_scrub = '0;
  rsp_t q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; cyc counts rising edges since reset release.
  task automatic nxt();
    rsp_t e;
    @(negedge clk);
    if (rst) cyc = 0; else cyc++;
    if (rsp_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL rsp_unexpected: observed rsp_valid=1 expected no response");
      end else begin
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.data);
        chk("rsp_err", rsp_err, e.err);
      end
    end
    if (scrub_done) done_cnt++;
    if (scrub_busy && !mem_we) last_scrub = mem_addr;
  endtask

  task automatic do_req(input logic we, input logic [3:0] a, input logic [7:0] d,
                        input logic [7:0] exp_d, input logic exp_e);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #1;
    for (int i = 0; i < 20 && !req_ready; i++) nxt();
    chk("req_accept", req_ready, 1);
    if (!we) q.push_back(rsp_t'({exp_e, exp_d}));
    nxt();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 200 && !scrub_busy; i++) nxt();
    chk("scrub_started", scrub_busy, 1);
  endtask

  initial begin
    // Reset values
    nxt(); nxt();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_scrub_busy", scrub_busy, 0);
    chk("rst_scrub_done", scrub_done, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b0;

    // First scrub of a clean array at the first interval tick
    nxt();
    chk("ready_after_rst", req_ready, 1);
    repeat (63) nxt();
    chk("start_cycle_ready", req_ready, 0);
    chk("start_cycle_busy", scrub_busy, 0);
    nxt();
    chk("scrub0_busy", scrub_busy, 1);
    chk("scrub0_addr", mem_addr, 0);
    chk("scrub0_we", mem_we, 0);
    nxt();
    chk("scrub0_idle", scrub_busy, 0);
    chk("scrub0_we_after", mem_we, 0);
    chk("scrub0_errcnt", err_count, 0);

    // Client write then read-back
    do_req(1'b1, 4'd3, 8'hA5, 8'h00, 1'b0);
    chk("wr_landed", tbmem[3], 8'hA5);
    do_req(1'b0, 4'd3, 8'h00, 8'hA5, 1'b0);

    // Correctable error found by the scrubber at the next address
    inj_en = 1'b1; inj_addr = 4'd1; inj_data = 8'h3C;
    wait_busy();
    chk("scrub1_addr", mem_addr, 1);
    chk("scrub1_rd_we", mem_we, 0);
    nxt();
    chk("scrub1_wr_busy", scrub_busy, 1);
    chk("scrub1_wr_we", mem_we, 1);
    chk("scrub1_wr_addr", mem_addr, 1);
    chk("scrub1_wr_data", mem_wdata, 8'h3C);
    nxt();
    chk("scrub1_idle", scrub_busy, 0);
    chk("scrub1_errcnt", err_count, 1);
    chk("scrub1_fixed", tbmem[1], 8'h3C);
    inj_en = 1'b0;
    do_req(1'b0, 4'd1, 8'h00, 8'h3C, 1'b0);

    // Client read of a flagged word: reported, never written back
    inj_en = 1'b1; inj_addr = 4'd5; inj_data = 8'h77;
    do_req(1'b0, 4'd5, 8'h00, 8'h77, 1'b1);
    nxt();
    chk("no_client_wb", tbmem[5], 8'h00);
    chk("errcnt_unchanged", err_count, 1);
    inj_en = 1'b0;

    // Back-to-back reads defer a pending scrub by exactly MAX_DEFER accepts
    tick_at  = (cyc / 64 + 1) * 64;
    deferred = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    #1;
    for (int i = 0; i < 200 && req_ready; i++) begin
      q.push_back(rsp_t'({1'b0, 8'hA5}));
      if (cyc >= tick_at) deferred++;
      nxt();
    end
    chk("defer_accepts", deferred, 8);
    chk("defer_start_cyc", cyc, tick_at + 8);
    chk("defer_start_ready", req_ready, 0);
    req_valid = 1'b0;
    nxt();
    chk("defer_scrub_busy", scrub_busy, 1);
    chk("defer_scrub_addr", mem_addr, 2);
    nxt();
    chk("defer_cleared", dut.defer_cnt, 0);
    chk("defer_idle", scrub_busy, 0);

    // Finish the sweep: one done pulse after address 15, then wrap to 0
    done_cnt = 0;
    for (int i = 0; i < 1200 && !scrub_done; i++) nxt();
    chk("sweep_done", scrub_done, 1);
    chk("sweep_last_addr", last_scrub, 15);
    chk("sweep_done_once", done_cnt, 1);
    nxt();
    chk("done_one_cycle", scrub_done, 0);
    wait_busy();
    chk("wrap_addr", mem_addr, 0);
    nxt();
    chk("wrap_done_count", done_cnt, 1);

    // Reset during the write-back cycle aborts the write
    inj_en = 1'b1; inj_addr = 4'd1; inj_data = 8'h5A;
    wait_busy();
    chk("abort_rd_addr", mem_addr, 1);
    nxt();
    chk("abort_wr_we", mem_we, 1);
    rst = 1'b1;
    #1;
    chk("abort_we_in_rst", mem_we, 0);
    chk("abort_busy_in_rst", scrub_busy, 0);
    chk("abort_ready_in_rst", req_ready, 0);
    nxt();
    rst = 1'b0;
    #1;
    chk("abort_errcnt", err_count, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_done", scrub_done, 0);
    chk("abort_busy", scrub_busy, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_no_write", tbmem[1], 8'h3C);
    chk("abort_ready", req_ready, 1);
    inj_en = 1'b0;
    nxt();

    chk("rsp_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
